// File: rtl/regfile_arbiter.sv
// regfile_arbiter: two-port round-robin arbiter owning a DEPTH x WIDTH register file.
//
// After reset an init sequencer zeroes every entry (one per cycle, busy = 1). Afterwards at
// most one read or write is granted per cycle; read data is registered and returned one cycle
// after the grant.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   a_req/a_we/a_addr/a_wdata  requester A transaction (held until a_gnt)
//   a_gnt                      A accepted this cycle (combinational)
//   a_rvalid/a_rdata           registered read response for A
//   b_*                        same set for requester B
//   busy                       high while the init sequencer runs
//
// Optional feature macro: REGFILE_ARBITER_FORMAL_EN compiles in embedded immediate
// assert/assume/cover statements; behaviour is identical either way.

module regfile_arbiter #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_req,
    input  logic             a_we,
    input  logic [AW-1:0]    a_addr,
    input  logic [WIDTH-1:0] a_wdata,
    output logic             a_gnt,
    output logic             a_rvalid,
    output logic [WIDTH-1:0] a_rdata,
    input  logic             b_req,
    input  logic             b_we,
    input  logic [AW-1:0]    b_addr,
    input  logic [WIDTH-1:0] b_wdata,
    output logic             b_gnt,
    output logic             b_rvalid,
    output logic [WIDTH-1:0] b_rdata,
    output logic             busy
);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [AW-1:0]    init_cnt_q, init_cnt_d;
    logic             prio_q, prio_d;  // 0 = A preferred, 1 = B preferred
    logic [WIDTH-1:0] regs_q [DEPTH];
    logic             a_rvalid_q, b_rvalid_q;
    logic [WIDTH-1:0] a_rdata_q, b_rdata_q;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        prio_d     = prio_q;
        a_gnt      = 1'b0;
        b_gnt      = 1'b0;
        busy       = 1'b0;
        case (state_q)
            StInit: begin
                busy       = 1'b1;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == LastIdx) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (a_req && b_req) begin
                    a_gnt = ~prio_q;
                    b_gnt = prio_q;
                end else begin
                    a_gnt = a_req;
                    b_gnt = b_req;
                end
                // Priority passes to whichever requester was not just served.
                if (a_gnt) begin
                    prio_d = 1'b1;
                end else if (b_gnt) begin
                    prio_d = 1'b0;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StInit;
            init_cnt_q <= '0;
            prio_q     <= 1'b0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            prio_q     <= prio_d;
            a_rvalid_q <= a_gnt && !a_we;
            b_rvalid_q <= b_gnt && !b_we;
            if (a_gnt && !a_we) begin
                a_rdata_q <= regs_q[a_addr];
            end
            if (b_gnt && !b_we) begin
                b_rdata_q <= regs_q[b_addr];
            end
        end
    end

    // Storage has no reset; its contents are defined by the init sequencer instead.
    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            regs_q[init_cnt_q] <= '0;
        end else if (a_gnt && a_we) begin
            regs_q[a_addr] <= a_wdata;
        end else if (b_gnt && b_we) begin
            regs_q[b_addr] <= b_wdata;
        end
    end

    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

`ifdef REGFILE_ARBITER_FORMAL_EN
    logic             f_past_valid;
    logic             f_a_wait, f_b_wait, f_contend;
    logic             f_a_we, f_b_we;
    logic [AW-1:0]    f_a_addr, f_b_addr, f_wr_addr;
    logic [WIDTH-1:0] f_a_wdata, f_b_wdata, f_a_past, f_b_past;
    logic             f_wr_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_past_valid <= 1'b0;
            f_a_wait     <= 1'b0;
            f_b_wait     <= 1'b0;
            f_contend    <= 1'b0;
            f_wr_valid   <= 1'b0;
        end else begin
            f_past_valid <= 1'b1;
            f_a_wait     <= a_req && !a_gnt && (state_q == StRun);
            f_b_wait     <= b_req && !b_gnt && (state_q == StRun);
            f_contend    <= a_req && b_req && (state_q == StRun);
            f_wr_valid   <= (a_gnt && a_we) || (b_gnt && b_we);
        end
    end

    // Snapshot of storage at the addressed entry, compared against the next-cycle read data.
    always_ff @(posedge clk) begin
        f_a_past  <= regs_q[a_addr];
        f_b_past  <= regs_q[b_addr];
        f_a_we    <= a_we;
        f_b_we    <= b_we;
        f_a_addr  <= a_addr;
        f_b_addr  <= b_addr;
        f_a_wdata <= a_wdata;
        f_b_wdata <= b_wdata;
        f_wr_addr <= a_gnt ? a_addr : b_addr;
    end

    always_comb begin
        assert (!(a_gnt && b_gnt));
        assert (!(busy && (a_gnt || b_gnt)));
        if (f_past_valid && a_rvalid) assert (a_rdata == f_a_past);
        if (f_past_valid && b_rvalid) assert (b_rdata == f_b_past);
        if (f_a_wait && (state_q == StRun)) assert (a_gnt);
        if (f_b_wait && (state_q == StRun)) assert (b_gnt);
        if (f_a_wait) assume (a_req && a_we == f_a_we && a_addr == f_a_addr
                              && a_wdata == f_a_wdata);
        if (f_b_wait) assume (b_req && b_we == f_b_we && b_addr == f_b_addr
                              && b_wdata == f_b_wdata);
        cover (f_contend && a_req && b_req && (a_gnt || b_gnt));
        cover (f_wr_valid && ((a_gnt && !a_we && a_addr == f_wr_addr)
                              || (b_gnt && !b_we && b_addr == f_wr_addr)));
    end
`endif

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter: drivers push expected read responses (data and
// arrival cycle) when a read is granted; a negedge monitor pops and compares on rvalid.

module tb_regfile_arbiter;

    logic       clk;
    logic       rst;
    logic       a_req, a_we, a_gnt, a_rvalid;
    logic [2:0] a_addr;
    logic [7:0] a_wdata, a_rdata;
    logic       b_req, b_we, b_gnt, b_rvalid;
    logic [2:0] b_addr;
    logic [7:0] b_wdata, b_rdata;
    logic       busy;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t e;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    regfile_arbiter #(
        .DEPTH(8),
        .WIDTH(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .a_req   (a_req),
        .a_we    (a_we),
        .a_addr  (a_addr),
        .a_wdata (a_wdata),
        .a_gnt   (a_gnt),
        .a_rvalid(a_rvalid),
        .a_rdata (a_rdata),
        .b_req   (b_req),
        .b_we    (b_we),
        .b_addr  (b_addr),
        .b_wdata (b_wdata),
        .b_gnt   (b_gnt),
        .b_rvalid(b_rvalid),
        .b_rdata (b_rdata),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one transaction, hold it until granted, report the grant cycle.
    task automatic drive(input bit port, input bit we, input logic [2:0] addr,
                         input logic [7:0] wdata, input bit push, input logic [7:0] exp,
                         output int gcyc);
        int waited = 0;
        bit got = 1'b0;
        gcyc = -1;
        if (!port) begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
        end else begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
        end
        while (!got && waited < 20) begin
            #2;
            if (!port ? a_gnt : b_gnt) begin
                got  = 1'b1;
                gcyc = cyc;
                if (!we && push) begin
                    if (!port) exp_a.push_back('{data: exp, cyc: cyc + 1});
                    else       exp_b.push_back('{data: exp, cyc: cyc + 1});
                end
            end
            tick();
            waited++;
        end
        if (!port) a_req = 1'b0;
        else       b_req = 1'b0;
        if (!got) check("grant_timeout", 32'(gcyc), 32'(cyc));
    endtask

    // Walk the DEPTH init cycles after reset release; optionally raise a B read in cycle 2.
    task automatic init_walk(input bit hold_b);
        for (int c = 0; c < 8; c++) begin
            if (hold_b && c == 2) begin
                b_req = 1'b1; b_we = 1'b0; b_addr = 3'd0; b_wdata = 8'h00;
            end
            #2;
            check("init_busy", 32'(busy), 1);
            check("init_a_gnt", 32'(a_gnt), 0);
            check("init_b_gnt", 32'(b_gnt), 0);
            tick();
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            check("mutex_gnt", 32'(a_gnt & b_gnt), 0);
            if (a_rvalid) begin
                if (exp_a.size() == 0) begin
                    check("a_rvalid_unexpected", 32'(a_rvalid), 0);
                end else begin
                    e = exp_a.pop_front();
                    check("a_rdata", 32'(a_rdata), 32'(e.data));
                    check("a_rvalid_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (b_rvalid) begin
                if (exp_b.size() == 0) begin
                    check("b_rvalid_unexpected", 32'(b_rvalid), 0);
                end else begin
                    e = exp_b.pop_front();
                    check("b_rdata", 32'(b_rdata), 32'(e.data));
                    check("b_rvalid_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        int g, ga, gb, s;
        rst = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_a_gnt", 32'(a_gnt), 0);
        check("rst_b_gnt", 32'(b_gnt), 0);
        check("rst_a_rvalid", 32'(a_rvalid), 0);
        check("rst_b_rvalid", 32'(b_rvalid), 0);
        check("rst_a_rdata", 32'(a_rdata), 0);
        check("rst_b_rdata", 32'(b_rdata), 0);
        check("rst_busy", 32'(busy), 1);
        tick();
        rst = 1'b0;

        // Init: B request raised in cycle 2 must wait until cycle 8.
        init_walk(1'b1);
        #2;
        check("run_busy", 32'(busy), 0);
        check("first_grant_b", 32'(b_gnt), 1);
        check("first_grant_not_a", 32'(a_gnt), 0);
        if (b_gnt) exp_b.push_back('{data: 8'h00, cyc: cyc + 1});
        tick();
        b_req = 1'b0;

        // Every entry reads back zero after init.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 3'(i), 8'h00, 1'b1, 8'h00, g);
        end
        drive(1'b1, 1'b0, 3'd7, 8'h00, 1'b1, 8'h00, g);

        // Write then read the same address on consecutive cycles.
        drive(1'b0, 1'b1, 3'd3, 8'hA5, 1'b0, 8'h00, ga);
        drive(1'b1, 1'b0, 3'd3, 8'h00, 1'b1, 8'hA5, gb);
        check("wr_rd_back_to_back", 32'(gb), 32'(ga + 1));

        // Continuous contention: last grant was B, so A leads and grants alternate.
        s = cyc;
        fork
            begin
                int gx;
                for (int i = 1; i <= 4; i++) begin
                    drive(1'b0, 1'b1, 3'(i), 8'(8'h10 + i), 1'b0, 8'h00, gx);
                    check("contend_a_slot", 32'(gx), 32'(s + 2 * (i - 1)));
                end
            end
            begin
                int gy;
                for (int i = 1; i <= 4; i++) begin
                    drive(1'b1, 1'b0, 3'(i), 8'h00, 1'b1, 8'(8'h10 + i), gy);
                    check("contend_b_slot", 32'(gy), 32'(s + 2 * i - 1));
                end
            end
        join

        // Reset right after a read grant drops the pending response and re-zeroes storage.
        drive(1'b0, 1'b1, 3'd5, 8'h3C, 1'b0, 8'h00, g);
        drive(1'b0, 1'b0, 3'd5, 8'h00, 1'b0, 8'h00, g);
        check("pre_rst_a_rvalid", 32'(a_rvalid), 1);
        check("pre_rst_a_rdata", 32'(a_rdata), 32'h3C);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_a_rvalid", 32'(a_rvalid), 0);
        check("mid_rst_a_rdata", 32'(a_rdata), 0);
        check("mid_rst_b_rdata", 32'(b_rdata), 0);
        check("mid_rst_busy", 32'(busy), 1);
        tick();
        rst = 1'b0;
        init_walk(1'b0);
        #1;
        check("reinit_busy", 32'(busy), 0);
        #1;
        drive(1'b0, 1'b0, 3'd5, 8'h00, 1'b1, 8'h00, g);
        drive(1'b1, 1'b0, 3'd3, 8'h00, 1'b1, 8'h00, g);

        tick();
        tick();
        check("exp_a_drained", 32'(exp_a.size()), 0);
        check("exp_b_drained", 32'(exp_b.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
